// File: rtl/mul_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared multiplier core.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requesters and models the multiplier.
interface mul_arbiter_if #(
  parameter int N      = 4,
  parameter int A1_LEN = 32,
  parameter int A2_LEN = 32
);
  localparam int PW = A1_LEN + A2_LEN;

  // requester side
  logic [N-1:0]        req_arm;
  logic [N*A1_LEN-1:0] req_a1;
  logic [N*A2_LEN-1:0] req_a2;
  logic [N*PW-1:0]     req_outn;
  logic [N-1:0]        req_fin;
  logic [N-1:0]        req_err;

  // shared multiplier side
  logic                mul_arm;
  logic [A1_LEN-1:0]   mul_a1;
  logic [A2_LEN-1:0]   mul_a2;
  logic [PW-1:0]       mul_outn;
  logic                mul_fin;

  modport slave (
    input  req_arm, req_a1, req_a2, mul_outn, mul_fin,
    output req_outn, req_fin, req_err, mul_arm, mul_a1, mul_a2
  );

  modport master (
    output req_arm, req_a1, req_a2, mul_outn, mul_fin,
    input  req_outn, req_fin, req_err, mul_arm, mul_a1, mul_a2
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential arm/fin multiplier among N
// requesters. Each requester gets a private product register and fin flag.
// Optional feature: define MUL_ARB_TIMEOUT_EN to abort an operation that has
// been in RUN for TIMEOUT cycles without mul_fin and flag it on req_err.
module mul_arbiter #(
  parameter int N       = 4,
  parameter int A1_LEN  = 32,
  parameter int A2_LEN  = 32,
  parameter int TIMEOUT = 80
) (
  input  logic          clk,
  input  logic          rst,
  mul_arbiter_if.slave  bus
);
  localparam int PW = A1_LEN + A2_LEN;
  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam logic [GW-1:0] LAST_RST = GW'(N - 1);

  // Reject configurations outside the supported range at elaboration.
  if ((N < 2) || (N > 8) || (TIMEOUT < 1)) begin : g_param_chk
    $error("mul_arbiter: N must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic              mul_arm_q, mul_arm_d;
  logic [A1_LEN-1:0] mul_a1_q, mul_a1_d;
  logic [A2_LEN-1:0] mul_a2_q, mul_a2_d;
  logic [N-1:0]      req_fin_q, req_fin_d;
  logic [PW-1:0]     outn_q [N];
  logic [PW-1:0]     outn_d [N];

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  logic [N-1:0]      req_err_q, req_err_d;
  logic [CW-1:0]     tmo_q, tmo_d;
`endif

  logic [A1_LEN-1:0] a1_arr [N];
  logic [A2_LEN-1:0] a2_arr [N];
  logic [N-1:0]      eligible_s;
  logic [GW-1:0]     pick_s;
  logic              pick_vld_s;

  // Unpack operand buses per requester and flatten product registers.
  for (genvar gi = 0; gi < N; gi++) begin : g_slices
    assign a1_arr[gi] = bus.req_a1[gi*A1_LEN +: A1_LEN];
    assign a2_arr[gi] = bus.req_a2[gi*A2_LEN +: A2_LEN];
    assign bus.req_outn[gi*PW +: PW] = outn_q[gi];
  end

  // A requester may compete only while armed with no pending fin or error.
`ifdef MUL_ARB_TIMEOUT_EN
  assign eligible_s = bus.req_arm & ~req_fin_q & ~req_err_q;
`else
  assign eligible_s = bus.req_arm & ~req_fin_q;
`endif

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    logic [GW-1:0] idx_v;
    pick_vld_s = 1'b0;
    pick_s     = last_q;
    idx_v      = last_q;
    for (int k = 1; k <= N; k++) begin
      idx_v = GW'((int'(last_q) + k) % N);
      if (!pick_vld_s && eligible_s[idx_v]) begin
        pick_vld_s = 1'b1;
        pick_s     = idx_v;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Next-state and next-output computation for the grant FSM.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    mul_arm_d = mul_arm_q;
    mul_a1_d  = mul_a1_q;
    mul_a2_d  = mul_a2_q;
    outn_d    = outn_q;
    // A fin is released on the first edge its arm is seen low, in any state.
    req_fin_d = req_fin_q & bus.req_arm;
`ifdef MUL_ARB_TIMEOUT_EN
    req_err_d = req_err_q & bus.req_arm;
    tmo_d     = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_s) begin
          grant_d   = pick_s;
          last_d    = pick_s;
          mul_a1_d  = a1_arr[pick_s];
          mul_a2_d  = a2_arr[pick_s];
          mul_arm_d = 1'b1;
`ifdef MUL_ARB_TIMEOUT_EN
          tmo_d     = '0;
`endif
          state_d   = ST_RUN;
        end else begin
          mul_arm_d = 1'b0;
        end
      end
      ST_RUN: begin
        mul_arm_d = 1'b1;
        mul_a1_d  = a1_arr[grant_q];
        mul_a2_d  = a2_arr[grant_q];
        // Abort wins over a coincident mul_fin: the requester no longer wants it.
        if (!bus.req_arm[grant_q]) begin
          mul_arm_d = 1'b0;
          state_d   = ST_REL;
        end else if (bus.mul_fin) begin
          outn_d[grant_q]    = bus.mul_outn;
          req_fin_d[grant_q] = 1'b1;
          mul_arm_d          = 1'b0;
          state_d            = ST_REL;
`ifdef MUL_ARB_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          req_err_d[grant_q] = 1'b1;
          mul_arm_d          = 1'b0;
          state_d            = ST_REL;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
`else
        end else begin
          state_d = ST_RUN;
        end
`endif
      end
      ST_REL: begin
        // One low cycle lets the core clear its internal counter.
        mul_arm_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        mul_arm_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      mul_arm_q <= 1'b0;
      mul_a1_q  <= '0;
      mul_a2_q  <= '0;
      req_fin_q <= '0;
      outn_q    <= '{default: '0};
`ifdef MUL_ARB_TIMEOUT_EN
      req_err_q <= '0;
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      mul_arm_q <= mul_arm_d;
      mul_a1_q  <= mul_a1_d;
      mul_a2_q  <= mul_a2_d;
      req_fin_q <= req_fin_d;
      outn_q    <= outn_d;
`ifdef MUL_ARB_TIMEOUT_EN
      req_err_q <= req_err_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign bus.mul_arm = mul_arm_q;
  assign bus.mul_a1  = mul_a1_q;
  assign bus.mul_a2  = mul_a2_q;
  assign bus.req_fin = req_fin_q;
`ifdef MUL_ARB_TIMEOUT_EN
  assign bus.req_err = req_err_q;
`else
  assign bus.req_err = '0;
`endif
endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a behavioural multiplier that raises
// mul_fin 34 cycles after it first sees mul_arm high.
module tb_mul_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int PW = 64;
  localparam int CORE_LAT = 34;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  bit   never_fin;
  int   m_cnt;

  int          exp_idx_q [$];
  logic [63:0] exp_p_q   [$];

  mul_arbiter_if #(.N(N), .A1_LEN(W), .A2_LEN(W)) bus ();

  mul_arbiter #(.N(N), .A1_LEN(W), .A2_LEN(W), .TIMEOUT(80)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sequential multiplier core.
  always @(posedge clk) begin
    if (rst || !bus.mul_arm) begin
      m_cnt       <= 0;
      bus.mul_fin <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (!never_fin && (m_cnt + 1 >= CORE_LAT)) begin
        bus.mul_fin  <= 1'b1;
        bus.mul_outn <= longint'($signed(bus.mul_a1)) * longint'($signed(bus.mul_a2));
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] a1, input logic [31:0] a2);
    bus.req_a1[idx*W +: W] = a1;
    bus.req_a2[idx*W +: W] = a2;
  endtask

  task automatic expect_fin(input int idx, input logic [63:0] p);
    exp_idx_q.push_back(idx);
    exp_p_q.push_back(p);
  endtask

  function automatic logic [63:0] outn(input int idx);
    return bus.req_outn[idx*PW +: PW];
  endfunction

  // Monitor: pops the scoreboard on each fin rise and checks arm gaps.
  initial begin
    logic [N-1:0] prev_fin;
    logic         prev_arm;
    bit           seen;
    int           gap;
    int           e_idx;
    logic [63:0]  e_p;
    prev_fin = '0;
    prev_arm = 1'b0;
    seen     = 1'b0;
    gap      = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        prev_fin = '0;
        prev_arm = 1'b0;
        seen     = 1'b0;
        gap      = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (bus.req_fin[i] && !prev_fin[i]) begin
            if (exp_idx_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL sb_unexpected: fin on requester %0d with empty scoreboard", i);
            end else begin
              e_idx = exp_idx_q.pop_front();
              e_p   = exp_p_q.pop_front();
              check("sb_idx", 64'(i), 64'(e_idx));
              check("sb_product", outn(i), e_p);
            end
          end
        end
        if (bus.mul_arm && !prev_arm) begin
          if (seen) begin
            tests++;
            if (gap < 2) begin
              fails++;
              $display("FAIL arm_gap: got %0d low cycles expected >= 2", gap);
            end
          end
          seen = 1'b1;
          gap  = 0;
        end else if (!bus.mul_arm) begin
          gap++;
        end
        prev_fin = bus.req_fin;
        prev_arm = bus.mul_arm;
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    int lat;
    int bad;
    bit ok;
    tests       = 0;
    fails       = 0;
    never_fin   = 1'b0;
    rst         = 1'b1;
    bus.req_arm = '0;
    bus.req_a1  = '0;
    bus.req_a2  = '0;
    repeat (3) tick();

    check("rst_mul_arm", 64'(bus.mul_arm), 64'd0);
    check("rst_mul_a1", 64'(bus.mul_a1), 64'd0);
    check("rst_mul_a2", 64'(bus.mul_a2), 64'd0);
    check("rst_req_fin", 64'(bus.req_fin), 64'd0);
    check("rst_req_err", 64'(bus.req_err), 64'd0);
    check("rst_req_outn3", outn(3), 64'd0);
    rst = 1'b0;

    // Contention: all four armed at once, grants must be 0,1,2,3.
    set_req(0, 32'd2, 32'd3);
    set_req(1, 32'hFFFF_FFFB, 32'd4);
    set_req(2, 32'd100000, 32'd100000);
    set_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_fin(0, 64'h0000_0000_0000_0006);
    expect_fin(1, 64'hFFFF_FFFF_FFFF_FFEC);
    expect_fin(2, 64'h0000_0002_540B_E400);
    expect_fin(3, 64'h0000_0000_0000_0001);
    bus.req_arm = 4'b1111;
    tick();
    check("cont_first_a1", 64'(bus.mul_a1), 64'd2);
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (bus.req_fin == 4'b1111) begin
        ok = 1'b1;
        break;
      end
    end
    check("cont_all_fin", 64'(ok), 64'd1);
    check("cont_outn2", outn(2), 64'h0000_0002_540B_E400);
    bus.req_arm = '0;
    tick();
    check("cont_fin_clear", 64'(bus.req_fin), 64'd0);

    // Single: -3 * 7, fin at cycle 36.
    set_req(0, 32'hFFFF_FFFD, 32'd7);
    expect_fin(0, 64'hFFFF_FFFF_FFFF_FFEB);
    bus.req_arm = 4'b0001;
    tick();
    check("single_arm", 64'(bus.mul_arm), 64'd1);
    check("single_a1", 64'(bus.mul_a1), 64'h0000_0000_FFFF_FFFD);
    lat = 1;
    while ((lat < 200) && !bus.req_fin[0]) begin
      tick();
      lat++;
    end
    check("single_latency", 64'(lat), 64'd36);
    check("single_outn", outn(0), 64'hFFFF_FFFF_FFFF_FFEB);

    // Hold: fin stays up and no re-grant while arm stays high.
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (!bus.req_fin[0] || bus.mul_arm) bad++;
    end
    check("hold_violations", 64'(bad), 64'd0);
    bus.req_arm = '0;
    tick();
    check("release_fin", 64'(bus.req_fin[0]), 64'd0);
    check("release_outn_held", outn(0), 64'hFFFF_FFFF_FFFF_FFEB);

    // Abort: requester 1 drops arm 10 cycles into RUN, requester 2 follows.
    set_req(1, 32'd9, 32'd9);
    set_req(2, 32'd12, 32'hFFFF_FFFE);
    expect_fin(2, 64'hFFFF_FFFF_FFFF_FFE8);
    bus.req_arm = 4'b0110;
    tick();
    check("abort_grant1_a1", 64'(bus.mul_a1), 64'd9);
    repeat (10) tick();
    bus.req_arm = 4'b0100;
    tick();
    check("abort_arm_drop", 64'(bus.mul_arm), 64'd0);
    check("abort_no_fin", 64'(bus.req_fin[1]), 64'd0);
    lat = 0;
    while ((lat < 20) && !bus.mul_arm) begin
      tick();
      lat++;
    end
    check("abort_regrant_delay", 64'(lat), 64'd2);
    check("abort_grant2_a1", 64'(bus.mul_a1), 64'd12);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (bus.req_fin[2]) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_fin2", 64'(ok), 64'd1);
    bus.req_arm = '0;
    tick();

    // Reset at RUN cycle 5, then requester 0 must win.
    set_req(3, 32'd5, 32'd6);
    set_req(0, 32'hFFFF_FFF9, 32'hFFFF_FFF8);
    bus.req_arm = 4'b1000;
    tick();
    check("rstrun_arm", 64'(bus.mul_arm), 64'd1);
    check("rstrun_a1", 64'(bus.mul_a1), 64'd5);
    repeat (4) tick();
    rst = 1'b1;
    bus.req_arm = 4'b1001;
    tick();
    check("rstrun_mul_arm", 64'(bus.mul_arm), 64'd0);
    check("rstrun_mul_a1", 64'(bus.mul_a1), 64'd0);
    check("rstrun_req_fin", 64'(bus.req_fin), 64'd0);
    check("rstrun_outn2", outn(2), 64'd0);
    rst = 1'b0;
    expect_fin(0, 64'h0000_0000_0000_0038);
    expect_fin(3, 64'h0000_0000_0000_001E);
    tick();
    check("rstrun_grant0_a1", 64'(bus.mul_a1), 64'h0000_0000_FFFF_FFF9);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (bus.req_fin == 4'b1001) begin
        ok = 1'b1;
        break;
      end
    end
    check("rstrun_both_fin", 64'(ok), 64'd1);
    bus.req_arm = '0;
    tick();

`ifdef MUL_ARB_TIMEOUT_EN
    // Timeout: core never fins, error raised after 80 RUN cycles.
    never_fin = 1'b1;
    set_req(1, 32'd3, 32'd3);
    bus.req_arm = 4'b0010;
    tick();
    check("tmo_arm", 64'(bus.mul_arm), 64'd1);
    lat = 0;
    while ((lat < 200) && !bus.req_err[1]) begin
      tick();
      lat++;
    end
    check("tmo_cycles", 64'(lat), 64'd80);
    check("tmo_arm_drop", 64'(bus.mul_arm), 64'd0);
    never_fin = 1'b0;
    set_req(2, 32'h0001_0000, 32'h0001_0000);
    expect_fin(2, 64'h0000_0001_0000_0000);
    bus.req_arm = 4'b0110;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (bus.req_fin[2]) begin
        ok = 1'b1;
        break;
      end
    end
    check("tmo_next_served", 64'(ok), 64'd1);
    check("tmo_err_sticky", 64'(bus.req_err[1]), 64'd1);
    bus.req_arm = 4'b0100;
    tick();
    check("tmo_err_clear", 64'(bus.req_err[1]), 64'd0);
    bus.req_arm = '0;
    tick();
`endif

    repeat (5) tick();
    check("sb_empty", 64'(exp_idx_q.size()), 64'd0);
    check("end_idle_arm", 64'(bus.mul_arm), 64'd0);
    check("end_err", 64'(bus.req_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
